// File: rtl/spart_pkg.sv
// Shared constants for the SPART register/bus interface: register addresses,
// status-register bit positions and the default baud divisor.
package spart_pkg;

    // Register map seen on ioaddr
    localparam logic [1:0] ADDR_BUF  = 2'b00;
    localparam logic [1:0] ADDR_STAT = 2'b01;
    localparam logic [1:0] ADDR_DBL  = 2'b10;
    localparam logic [1:0] ADDR_DBH  = 2'b11;

    // Bit positions inside the status byte
    localparam int STAT_RDA = 0;
    localparam int STAT_TBR = 1;
    localparam int STAT_OVR = 2;

    // 50 MHz / (16 * 9600) - 1 rounded: 326-cycle tick period
    localparam logic [15:0] DB_RESET_DEF = 16'd325;

    // Assemble the status byte from its individual flags
    function automatic logic [7:0] pack_status(input logic rda, input logic tbr, input logic ovr);
        logic [7:0] s;
        s           = 8'h00;
        s[STAT_RDA] = rda;
        s[STAT_TBR] = tbr;
        s[STAT_OVR] = ovr;
        return s;
    endfunction

endpackage

// File: rtl/spart_brg.sv
// SPART baud-rate generator: holds the 16-bit divisor, runs a down counter
// and emits a one-cycle 16x baud tick each time the counter reaches zero.
// A divisor of zero keeps the counter parked at zero, so the tick stays high.
module spart_brg
    import spart_pkg::*;
#(
    parameter logic [15:0] DB_RESET = DB_RESET_DEF
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_wr_lo,
    input  logic        i_wr_hi,
    input  logic [7:0]  i_wdata,
    output logic [15:0] o_db,
    output logic        o_brg_en
);

    logic [15:0] r_db;
    logic [15:0] r_cnt;
    logic [15:0] w_db_next;
    logic        w_db_wr;
    logic        w_cnt_zero;

    assign w_db_wr    = i_wr_lo | i_wr_hi;
    assign w_cnt_zero = (r_cnt == 16'd0);

    // Merge a byte-wide divisor write into the current divisor value
    always_comb begin
        w_db_next = r_db;
        if (i_wr_lo) w_db_next[7:0]  = i_wdata;
        if (i_wr_hi) w_db_next[15:8] = i_wdata;
    end

    // Divisor register and down counter; any divisor write restarts the count
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_db  <= DB_RESET;
            r_cnt <= DB_RESET;
        end else begin
            r_db <= w_db_next;
            if (w_db_wr) begin
                r_cnt <= w_db_next;
            end else if (w_cnt_zero) begin
                r_cnt <= r_db;
            end else begin
                r_cnt <= r_cnt - 16'd1;
            end
        end
    end

    assign o_db     = r_db;
    assign o_brg_en = w_cnt_zero;

endmodule

// File: rtl/spart_bus_if.sv
// SPART register/bus interface: decodes processor accesses, drives the shared
// databus on reads, buffers TX/RX bytes and hosts the baud-rate generator.
// Optional feature: define SPART_OVERRUN_EN to add a receive-overrun flag in
// status bit 2 (cleared by a status read); otherwise that bit reads 0.
module spart_bus_if
    import spart_pkg::*;
#(
    parameter logic [15:0] DB_RESET = DB_RESET_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    output logic       rda,
    output logic       tbr,
    output logic [7:0] tx_data,
    output logic       tx_load,
    input  logic       tx_busy,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       brg_en
);

    logic        r_tbr;
    logic        r_rda;
    logic        r_tx_load;
    logic [7:0]  r_tx_buf;
    logic [7:0]  r_rx_buf;
    logic        w_ovr;

    logic        w_rd_en;
    logic        w_wr_en;
    logic        w_rd_buf;
    logic        w_rd_stat;
    logic        w_wr_buf;
    logic        w_wr_dbl;
    logic        w_wr_dbh;
    logic [7:0]  w_rd_data;
    logic [7:0]  w_wdata;
    logic [15:0] w_db;

    assign w_rd_en   = iocs & iorw;
    assign w_wr_en   = iocs & ~iorw;
    assign w_rd_buf  = w_rd_en & (ioaddr == ADDR_BUF);
    assign w_rd_stat = w_rd_en & (ioaddr == ADDR_STAT);
    assign w_wr_buf  = w_wr_en & (ioaddr == ADDR_BUF);
    assign w_wr_dbl  = w_wr_en & (ioaddr == ADDR_DBL);
    assign w_wr_dbh  = w_wr_en & (ioaddr == ADDR_DBH);
    assign w_wdata   = databus;

    // TX buffer: accept a write only when empty, then hand it to the
    // transmitter with a one-cycle load pulse as soon as it is idle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tbr     <= 1'b1;
            r_tx_buf  <= 8'h00;
            r_tx_load <= 1'b0;
        end else begin
            r_tx_load <= 1'b0;
            if (w_wr_buf && r_tbr) begin
                r_tx_buf <= w_wdata;
                r_tbr    <= 1'b0;
            end else if (!r_tbr && !tx_busy) begin
                r_tx_load <= 1'b1;
                r_tbr     <= 1'b1;
            end
        end
    end

    // RX buffer: a new byte always wins over a coincident buffer read
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_buf <= 8'h00;
            r_rda    <= 1'b0;
        end else begin
            if (rx_valid) begin
                r_rx_buf <= rx_data;
                r_rda    <= 1'b1;
            end else if (w_rd_buf) begin
                r_rda    <= 1'b0;
            end
        end
    end

`ifdef SPART_OVERRUN_EN
    logic r_ovr;

    // Overrun: a byte arrived while the previous one was still unread
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ovr <= 1'b0;
        end else begin
            if (rx_valid && r_rda) begin
                r_ovr <= 1'b1;
            end else if (w_rd_stat) begin
                r_ovr <= 1'b0;
            end
        end
    end

    assign w_ovr = r_ovr;
`else
    assign w_ovr = 1'b0;
`endif

    // Combinational read mux for the addressed register
    always_comb begin
        w_rd_data = 8'h00;
        case (ioaddr)
            ADDR_BUF:  w_rd_data = r_rx_buf;
            ADDR_STAT: w_rd_data = pack_status(r_rda, r_tbr, w_ovr);
            ADDR_DBL:  w_rd_data = w_db[7:0];
            ADDR_DBH:  w_rd_data = w_db[15:8];
            default:   w_rd_data = 8'h00;
        endcase
    end

    assign databus = w_rd_en ? w_rd_data : 8'bzzzz_zzzz;

    spart_brg #(
        .DB_RESET (DB_RESET)
    ) u_brg (
        .i_clk    (clk),
        .i_rst_n  (rst),
        .i_wr_lo  (w_wr_dbl),
        .i_wr_hi  (w_wr_dbh),
        .i_wdata  (w_wdata),
        .o_db     (w_db),
        .o_brg_en (brg_en)
    );

    assign rda     = r_rda;
    assign tbr     = r_tbr;
    assign tx_data = r_tx_buf;
    assign tx_load = r_tx_load;

endmodule

// File: tb/tb_spart_bus_if.sv
// Self-checking bench for spart_bus_if. Transmit bytes accepted by the DUT
// are queued and compared against each tx_load pulse; register reads are
// compared against a small model of the RX/status/divisor state.
module tb_spart_bus_if;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       iocs = 1'b0;
    logic       iorw = 1'b0;
    logic [1:0] ioaddr = 2'b00;
    wire  [7:0] databus;
    logic       rda;
    logic       tbr;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       tx_busy = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       brg_en;

    logic       tb_oe = 1'b0;
    logic [7:0] tb_dout = 8'h00;
    assign databus = tb_oe ? tb_dout : 8'bzzzz_zzzz;

    int n_chk = 0;
    int n_err = 0;
    int n_load = 0;
    int n_load_exp = 0;
    logic [7:0] txq[$];

    // Model state
    logic       rda_m = 1'b0;
    logic       ovr_m = 1'b0;
    logic [7:0] rxbuf_m = 8'h00;

    always #5 clk = ~clk;

    spart_bus_if dut (
        .clk      (clk),
        .rst      (rst),
        .iocs     (iocs),
        .iorw     (iorw),
        .ioaddr   (ioaddr),
        .databus  (databus),
        .rda      (rda),
        .tbr      (tbr),
        .tx_data  (tx_data),
        .tx_load  (tx_load),
        .tx_busy  (tx_busy),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .brg_en   (brg_en)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] stat_m();
        logic [7:0] s;
        s = {6'b0, 1'b1, rda_m};
`ifdef SPART_OVERRUN_EN
        s[2] = ovr_m;
`endif
        return s;
    endfunction

    // Every load pulse must match the oldest accepted byte
    always @(negedge clk) begin
        if (rst && tx_load) begin
            n_load++;
            if (txq.size() == 0) chk("tx_load_unexpected", 32'd1, 32'd0);
            else chk("tx_data", {24'h0, tx_data}, {24'h0, txq.pop_front()});
        end
    end

    // All tasks start and end just after a falling edge
    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        iocs = 1'b1; iorw = 1'b0; ioaddr = a; tb_oe = 1'b1; tb_dout = d;
        @(negedge clk);
        iocs = 1'b0; tb_oe = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        iocs = 1'b1; iorw = 1'b1; ioaddr = a;
        #1 d = databus;
        @(negedge clk);
        iocs = 1'b0; iorw = 1'b0;
    endtask

    task automatic rx_pulse(input logic [7:0] d);
        rx_valid = 1'b1; rx_data = d;
        @(negedge clk);
        rx_valid = 1'b0;
        if (rda_m) ovr_m = 1'b1;
        rda_m = 1'b1; rxbuf_m = d;
    endtask

    task automatic brg_period(input string tag, input int exp);
        int n;
        n = 0;
        while (!brg_en && n < 2000) begin @(negedge clk); n++; end
        if (!brg_en) begin
            chk({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            n = 0;
            do begin @(negedge clk); n++; end while (!brg_en && n < 2000);
            chk(tag, n, exp);
        end
    endtask

    initial begin
        logic [7:0] d;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_tbr", {31'b0, tbr}, 32'd1);
        chk("rst_rda", {31'b0, rda}, 32'd0);
        chk("rst_tx_load", {31'b0, tx_load}, 32'd0);
        chk("rst_tx_data", {24'b0, tx_data}, 32'd0);
        chk("rst_brg_en", {31'b0, brg_en}, 32'd0);
        rst = 1'b1;

        bus_read(2'b10, d); chk("rst_dbl", {24'b0, d}, 32'h45);
        bus_read(2'b11, d); chk("rst_dbh", {24'b0, d}, 32'h01);
        bus_read(2'b01, d); chk("rst_stat", {24'b0, d}, {24'b0, stat_m()});

        // Default divisor: one tick every 326 cycles
        for (int i = 0; i < 3; i++) brg_period("brg_326", 326);

        // Deselected: DUT must leave the bus to the bench
        iocs = 1'b0; iorw = 1'b1; ioaddr = 2'b01; tb_oe = 1'b1; tb_dout = 8'hC3;
        #1 chk("hiz", {24'b0, databus}, 32'hC3);
        @(negedge clk); tb_oe = 1'b0; iorw = 1'b0;

        // Divide-by-zero: tick held high
        bus_write(2'b10, 8'h00);
        bus_write(2'b11, 8'h00);
        for (int i = 0; i < 4; i++) begin
            chk("brg_db0", {31'b0, brg_en}, 32'd1);
            @(negedge clk);
        end

        // Small divisor
        bus_write(2'b10, 8'h03);
        bus_write(2'b11, 8'h00);
        brg_period("brg_4a", 4);
        brg_period("brg_4b", 4);
        bus_read(2'b10, d); chk("dbl_03", {24'b0, d}, 32'h03);
        bus_read(2'b11, d); chk("dbh_00", {24'b0, d}, 32'h00);

        // Transmit with idle transmitter
        tx_busy = 1'b0;
        chk("tx_tbr_pre", {31'b0, tbr}, 32'd1);
        bus_write(2'b00, 8'hA5); txq.push_back(8'hA5); n_load_exp++;
        chk("tx_tbr_low", {31'b0, tbr}, 32'd0);
        @(negedge clk);
        chk("tx_tbr_back", {31'b0, tbr}, 32'd1);
        @(negedge clk);

        // Busy transmitter: second write while full is dropped
        tx_busy = 1'b1;
        bus_write(2'b00, 8'h96); txq.push_back(8'h96); n_load_exp++;
        chk("txb_tbr_low", {31'b0, tbr}, 32'd0);
        bus_write(2'b00, 8'h5A);
        repeat (3) @(negedge clk);
        chk("txb_tbr_hold", {31'b0, tbr}, 32'd0);
        tx_busy = 1'b0;
        repeat (2) @(negedge clk);
        chk("txb_tbr_back", {31'b0, tbr}, 32'd1);

        // Receive then read
        rx_pulse(8'h3C);
        chk("rx_rda", {31'b0, rda}, 32'd1);
        bus_read(2'b00, d); chk("rx_buf", {24'b0, d}, {24'b0, rxbuf_m});
        rda_m = 1'b0;
        chk("rx_rda_clr", {31'b0, rda}, 32'd0);
        bus_read(2'b01, d); chk("rx_stat", {24'b0, d}, 32'h02);

        // Two bytes without a read
        rx_pulse(8'h11);
        rx_pulse(8'h22);
        bus_read(2'b01, d); chk("ovr_stat1", {24'b0, d}, {24'b0, stat_m()});
        ovr_m = 1'b0;
        bus_read(2'b01, d); chk("ovr_stat2", {24'b0, d}, 32'h03);
        bus_read(2'b00, d); chk("ovr_buf", {24'b0, d}, 32'h22);
        rda_m = 1'b0;
        chk("ovr_rda_clr", {31'b0, rda}, 32'd0);

        // New byte coincident with a buffer read: the new byte wins
        rx_pulse(8'h55);
        iocs = 1'b1; iorw = 1'b1; ioaddr = 2'b00; rx_valid = 1'b1; rx_data = 8'h44;
        #1 chk("coin_old", {24'b0, databus}, 32'h55);
        @(negedge clk);
        iocs = 1'b0; iorw = 1'b0; rx_valid = 1'b0;
        chk("coin_rda", {31'b0, rda}, 32'd1);
        bus_read(2'b00, d); chk("coin_new", {24'b0, d}, 32'h44);

        // Reset during a pending transmit
        bus_write(2'b10, 8'h10);
        tx_busy = 1'b1;
        bus_write(2'b00, 8'h77);
        chk("rtx_tbr_low", {31'b0, tbr}, 32'd0);
        #2 rst = 1'b0;
        #1 chk("rtx_tbr", {31'b0, tbr}, 32'd1);
        @(negedge clk);
        rst = 1'b1; tx_busy = 1'b0;
        rda_m = 1'b0; ovr_m = 1'b0;
        repeat (3) @(negedge clk);
        bus_read(2'b10, d); chk("rtx_dbl", {24'b0, d}, 32'h45);
        bus_read(2'b11, d); chk("rtx_dbh", {24'b0, d}, 32'h01);
        bus_read(2'b01, d); chk("rtx_stat", {24'b0, d}, {24'b0, stat_m()});

        chk("txq_empty", txq.size(), 32'd0);
        chk("load_count", n_load, n_load_exp);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
